// File: rtl/cursor_blink_controller.sv
// Edit-cursor controller: debounced left/right buttons move a cursor over the
// display digits, drive a one-hot load vector, and strobe blinkPulse.

// Per-button input path: 2-flop synchronizer followed by a debounce FSM that
// emits a one-cycle step strobe when a press has been stable long enough.
//
// state        | meaning
// -------------+-------------------------------------------------------------
// RELEASED     | button idle, waiting for synchronized level to go high
// PRESS_WAIT   | level high, counting stable cycles before accepting press
// PRESSED      | press accepted (step already issued), waiting for release
// RELEASE_WAIT | level low, counting stable cycles before accepting release
module cursor_blink_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic resetn,
    input  logic raw,
    output logic step
);
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DW-1:0] LAST = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    state_t          state, state_next;
    logic [1:0]      sync_q;
    logic            sync;
    logic [DW-1:0]   cnt, cnt_next;

    assign sync = sync_q[1];

    // Bring the raw asynchronous button level into the clock domain.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) sync_q <= 2'b00;
        else         sync_q <= {sync_q[0], raw};
    end

    // Debounce state and stability counter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= RELEASED;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state logic; the step strobe marks the PRESS_WAIT->PRESSED edge only,
    // so a held button yields exactly one step.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        step       = 1'b0;
        case (state)
            RELEASED: begin
                if (sync) begin
                    state_next = PRESS_WAIT;
                    cnt_next   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!sync) begin
                    state_next = RELEASED;
                    cnt_next   = '0;
                end else if (cnt == LAST) begin
                    state_next = PRESSED;
                    cnt_next   = '0;
                    step       = 1'b1;
                end else begin
                    cnt_next = cnt + DW'(1);
                end
            end
            PRESSED: begin
                if (!sync) begin
                    state_next = RELEASE_WAIT;
                    cnt_next   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (sync) begin
                    state_next = PRESSED;
                    cnt_next   = '0;
                end else if (cnt == LAST) begin
                    state_next = RELEASED;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + DW'(1);
                end
            end
            default: begin
                state_next = RELEASED;
                cnt_next   = '0;
            end
        endcase
    end
endmodule

module cursor_blink_controller #(
    parameter  int NUM_DIGITS      = 4,
    parameter  int BLINK_PERIOD    = 25000000,
    parameter  int DEBOUNCE_CYCLES = 500000,
    localparam int CW              = $clog2(NUM_DIGITS)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  enable,
    input  logic                  btnLeft,
    input  logic                  btnRight,
    output logic                  blinkPulse,
    output logic [NUM_DIGITS-1:0] load,
    output logic [CW-1:0]         cursor
);
    localparam int BW = $clog2(BLINK_PERIOD);
    localparam logic [BW-1:0] BLINK_LAST  = BW'(BLINK_PERIOD - 1);
    localparam logic [CW-1:0] CURSOR_LAST = CW'(NUM_DIGITS - 1);

    logic          step_left, step_right;
    logic          move;
    logic [BW-1:0] blink_cnt;

    cursor_blink_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_left (
        .clk    (clk),
        .resetn (resetn),
        .raw    (btnLeft),
        .step   (step_left)
    );

    cursor_blink_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_right (
        .clk    (clk),
        .resetn (resetn),
        .raw    (btnRight),
        .step   (step_right)
    );

    // Opposite steps in the same cycle cancel; steps while disabled are dropped.
    assign move = enable && (step_left ^ step_right);

    // A move suppresses a coincident terminal count so the new digit gets a full period.
    assign blinkPulse = enable && !move && (blink_cnt == BLINK_LAST);

    // Cursor position with wrap in both directions.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cursor <= '0;
        end else if (move) begin
            if (step_right) cursor <= (cursor == CURSOR_LAST) ? '0 : cursor + CW'(1);
            else            cursor <= (cursor == '0) ? CURSOR_LAST : cursor - CW'(1);
        end
    end

    // Registered one-hot digit select, lagging cursor/enable by one cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) load <= '0;
        else         load <= enable ? (NUM_DIGITS'(1) << cursor) : '0;
    end

    // Blink period counter; restarts on disable and on every cursor move.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                      blink_cnt <= '0;
        else if (!enable || move)         blink_cnt <= '0;
        else if (blink_cnt == BLINK_LAST) blink_cnt <= '0;
        else                              blink_cnt <= blink_cnt + BW'(1);
    end
endmodule

// File: tb/tb_cursor_blink_controller.sv
// Directed bench for cursor_blink_controller (NUM_DIGITS=4, BLINK_PERIOD=8, DEBOUNCE_CYCLES=4).
module tb_cursor_blink_controller;
    logic       clk = 1'b0;
    logic       resetn;
    logic       enable;
    logic       btnLeft;
    logic       btnRight;
    logic       blinkPulse;
    logic [3:0] load;
    logic [1:0] cursor;

    int errors = 0;
    int checks = 0;

    cursor_blink_controller #(
        .NUM_DIGITS      (4),
        .BLINK_PERIOD    (8),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .enable     (enable),
        .btnLeft    (btnLeft),
        .btnRight   (btnRight),
        .blinkPulse (blinkPulse),
        .load       (load),
        .cursor     (cursor)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Press a button (or both) cleanly, hold, release, and let the release settle.
    task automatic press(input logic l, input logic r);
        btnLeft  = l;
        btnRight = r;
        tick(10);
        btnLeft  = 1'b0;
        btnRight = 1'b0;
        tick(12);
    endtask

    task automatic test_reset();
        resetn   = 1'b0;
        enable   = 1'b0;
        btnLeft  = 1'b0;
        btnRight = 1'b0;
        tick(3);
        checks++;
        if (cursor !== 2'd0) begin errors++; $display("FAIL reset_cursor got=%0d exp=0", cursor); end
        checks++;
        if (load !== 4'b0000) begin errors++; $display("FAIL reset_load got=%b exp=0000", load); end
        checks++;
        if (blinkPulse !== 1'b0) begin errors++; $display("FAIL reset_pulse got=%b exp=0", blinkPulse); end
        resetn = 1'b1;
        tick(2);
    endtask

    task automatic test_blink();
        enable = 1'b1;
        for (int i = 1; i <= 24; i++) begin
            checks++;
            if (blinkPulse !== ((i % 8) == 0)) begin
                errors++;
                $display("FAIL blink_cycle%0d got=%b exp=%b", i, blinkPulse, (i % 8) == 0);
            end
            tick();
            if (i == 1) begin
                checks++;
                if (load !== 4'b0001) begin errors++; $display("FAIL blink_load got=%b exp=0001", load); end
            end
        end
    endtask

    task automatic test_press_hold();
        logic [1:0] exp_cur;
        logic [3:0] exp_load;
        btnRight = 1'b1;
        for (int i = 0; i < 20; i++) begin
            exp_cur  = (i >= 7) ? 2'd1 : 2'd0;
            exp_load = (i >= 8) ? 4'b0010 : 4'b0001;
            checks++;
            if (cursor !== exp_cur) begin errors++; $display("FAIL hold_cursor cyc%0d got=%0d exp=%0d", i, cursor, exp_cur); end
            checks++;
            if (load !== exp_load) begin errors++; $display("FAIL hold_load cyc%0d got=%b exp=%b", i, load, exp_load); end
            checks++;
            if (blinkPulse !== (i == 14)) begin errors++; $display("FAIL hold_pulse cyc%0d got=%b exp=%b", i, blinkPulse, i == 14); end
            tick();
        end
        btnRight = 1'b0;
        tick(12);
        checks++;
        if (cursor !== 2'd1) begin errors++; $display("FAIL hold_after_release got=%0d exp=1", cursor); end
    endtask

    task automatic test_bounce();
        btnRight = 1'b1; tick(3);
        btnRight = 1'b0; tick(2);
        btnRight = 1'b1; tick(3);
        btnRight = 1'b0;
        for (int i = 0; i < 15; i++) begin
            checks++;
            if (cursor !== 2'd1) begin errors++; $display("FAIL bounce_cursor cyc%0d got=%0d exp=1", i, cursor); end
            tick();
        end
        btnRight = 1'b1;
        tick(6);
        checks++;
        if (cursor !== 2'd1) begin errors++; $display("FAIL bounce_early got=%0d exp=1", cursor); end
        tick();
        checks++;
        if (cursor !== 2'd2) begin errors++; $display("FAIL bounce_step got=%0d exp=2", cursor); end
        tick(10);
        btnRight = 1'b0;
        tick(12);
        checks++;
        if (cursor !== 2'd2) begin errors++; $display("FAIL bounce_single got=%0d exp=2", cursor); end
    endtask

    task automatic test_wrap();
        press(1'b0, 1'b1);
        checks++;
        if (cursor !== 2'd3) begin errors++; $display("FAIL wrap_to3 got=%0d exp=3", cursor); end
        press(1'b0, 1'b1);
        checks++;
        if (cursor !== 2'd0) begin errors++; $display("FAIL wrap_3to0 got=%0d exp=0", cursor); end
        press(1'b1, 1'b0);
        checks++;
        if (cursor !== 2'd3) begin errors++; $display("FAIL wrap_left got=%0d exp=3", cursor); end
        checks++;
        if (load !== 4'b1000) begin errors++; $display("FAIL wrap_left_load got=%b exp=1000", load); end
        press(1'b0, 1'b1);
        checks++;
        if (cursor !== 2'd0) begin errors++; $display("FAIL wrap_right got=%0d exp=0", cursor); end
        checks++;
        if (load !== 4'b0001) begin errors++; $display("FAIL wrap_right_load got=%b exp=0001", load); end
    endtask

    task automatic test_simul_disable();
        press(1'b1, 1'b1);
        checks++;
        if (cursor !== 2'd0) begin errors++; $display("FAIL simul_cursor got=%0d exp=0", cursor); end
        press(1'b0, 1'b1);
        checks++;
        if (cursor !== 2'd1) begin errors++; $display("FAIL simul_then_right got=%0d exp=1", cursor); end
        enable = 1'b0;
        tick();
        btnRight = 1'b1;
        for (int i = 0; i < 22; i++) begin
            if (i == 10) btnRight = 1'b0;
            checks++;
            if (load !== 4'b0000) begin errors++; $display("FAIL dis_load cyc%0d got=%b exp=0000", i, load); end
            checks++;
            if (blinkPulse !== 1'b0) begin errors++; $display("FAIL dis_pulse cyc%0d got=%b exp=0", i, blinkPulse); end
            tick();
        end
        checks++;
        if (cursor !== 2'd1) begin errors++; $display("FAIL dis_cursor got=%0d exp=1", cursor); end
        enable = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            checks++;
            if (blinkPulse !== (i == 8)) begin errors++; $display("FAIL reen_pulse cyc%0d got=%b exp=%b", i, blinkPulse, i == 8); end
            tick();
            if (i == 1) begin
                checks++;
                if (load !== 4'b0010) begin errors++; $display("FAIL reen_load got=%b exp=0010", load); end
            end
        end
        checks++;
        if (cursor !== 2'd1) begin errors++; $display("FAIL reen_cursor got=%0d exp=1", cursor); end
    endtask

    task automatic test_async_reset();
        press(1'b0, 1'b1);
        checks++;
        if (cursor !== 2'd2) begin errors++; $display("FAIL arst_pre got=%0d exp=2", cursor); end
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if (cursor !== 2'd0) begin errors++; $display("FAIL arst_cursor got=%0d exp=0", cursor); end
        checks++;
        if (load !== 4'b0000) begin errors++; $display("FAIL arst_load got=%b exp=0000", load); end
        checks++;
        if (blinkPulse !== 1'b0) begin errors++; $display("FAIL arst_pulse got=%b exp=0", blinkPulse); end
        tick(2);
        resetn = 1'b1;
        tick();
        checks++;
        if (cursor !== 2'd0) begin errors++; $display("FAIL arst_release_cursor got=%0d exp=0", cursor); end
        checks++;
        if (load !== 4'b0001) begin errors++; $display("FAIL arst_release_load got=%b exp=0001", load); end
    endtask

    initial begin
        test_reset();
        test_blink();
        test_press_hold();
        test_bounce();
        test_wrap();
        test_simul_disable();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
